// File: rtl/regbank_if.sv
// Host byte bus between the interface decoder and the register bank.
interface regbank_if #(
  parameter int ADDR_W = 6
);
  logic              reg_rd_en_i;
  logic [ADDR_W-1:0] reg_rd_addr_i;
  logic [7:0]        reg_rd_data_o;
  logic              reg_wr_en_i;
  logic [ADDR_W-1:0] reg_wr_addr_i;
  logic [7:0]        reg_wr_data_i;

  modport master (
    output reg_rd_en_i, reg_rd_addr_i, reg_wr_en_i, reg_wr_addr_i, reg_wr_data_i,
    input  reg_rd_data_o
  );

  modport slave (
    input  reg_rd_en_i, reg_rd_addr_i, reg_wr_en_i, reg_wr_addr_i, reg_wr_data_i,
    output reg_rd_data_o
  );
endinterface

// File: rtl/regbank.sv
// Byte-addressed register bank for the frequency-meter control path.
// Gate time is staged byte by byte and committed atomically by the top byte;
// channel results are captured atomically and read through a shared snapshot
// that is loaded by each channel's byte-0 read.
module regbank #(
  parameter int          CHANNELS          = 3,
  parameter int          ADDR_W            = 6,
  parameter logic [31:0] DEFAULT_GATE_TIME = 32'd1000000,
  parameter logic [3:0]  REV_MAJOR         = 4'd1,
  parameter logic [3:0]  REV_MINOR         = 4'd0
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  regbank_if.slave                bus_if,
  input  logic                    res_valid_i,
  input  logic [32*CHANNELS-1:0]  res_data_i,
  output logic [31:0]             reg_gate_time_o,
  output logic                    reg_gate_upd_o,
  output logic                    reg_res_ready_o
);

  localparam logic [7:0]        ID_VALUE = 8'hD5;
  localparam logic [ADDR_W-1:0] A_ID     = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_REV    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_GATE0  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_GATE1  = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_GATE2  = ADDR_W'(6);
  localparam logic [ADDR_W-1:0] A_GATE3  = ADDR_W'(7);

  logic [31:0]                gate_q, gate_d;
  logic [31:0]                stage_q, stage_d;
  logic                       gate_upd_q, gate_upd_d;
  logic                       res_ready_q, res_ready_d;
  logic [CHANNELS-1:0][31:0]  res_q;
  logic [31:0]                snap_q, snap_d;
  logic [7:0]                 rd_data_q, rd_data_d;
  logic                       ctrl_clr;
  logic [7:0]                 rd_byte;
  logic                       snap_ld;
  logic [31:0]                snap_src;

  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  // Write decode: staging bytes, commit on the top byte, control clear
  always_comb begin
    stage_d    = stage_q;
    gate_d     = gate_q;
    gate_upd_d = 1'b0;
    ctrl_clr   = 1'b0;
    if (bus_if.reg_wr_en_i) begin
      case (bus_if.reg_wr_addr_i)
        A_CTRL:  ctrl_clr = bus_if.reg_wr_data_i[0];
        A_GATE0: stage_d[7:0]   = bus_if.reg_wr_data_i;
        A_GATE1: stage_d[15:8]  = bus_if.reg_wr_data_i;
        A_GATE2: stage_d[23:16] = bus_if.reg_wr_data_i;
        A_GATE3: begin
          stage_d[31:24] = bus_if.reg_wr_data_i;
          gate_d         = {bus_if.reg_wr_data_i, stage_q[23:0]};
          gate_upd_d     = 1'b1;
        end
        default: ;
      endcase
    end
    // A new result set wins over a simultaneous clear
    res_ready_d = res_valid_i ? 1'b1 : (ctrl_clr ? 1'b0 : res_ready_q);
  end

  // Read decode: fixed registers, committed gate bytes, snapshot-based results
  always_comb begin
    rd_byte  = 8'h00;
    snap_ld  = 1'b0;
    snap_src = snap_q;
    case (bus_if.reg_rd_addr_i)
      A_ID:     rd_byte = ID_VALUE;
      A_REV:    rd_byte = {REV_MAJOR, REV_MINOR};
      A_STATUS: rd_byte = {7'b0, res_ready_q};
      A_CTRL:   rd_byte = 8'h00;
      A_GATE0, A_GATE1, A_GATE2, A_GATE3:
                rd_byte = pick_byte(gate_q, bus_if.reg_rd_addr_i[1:0]);
      default: begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (bus_if.reg_rd_addr_i[ADDR_W-1:2] == (ADDR_W-2)'(c + 2)) begin
            if (bus_if.reg_rd_addr_i[1:0] == 2'd0) begin
              rd_byte  = res_q[c][7:0];
              snap_ld  = 1'b1;
              snap_src = res_q[c];
            end else begin
              rd_byte = pick_byte(snap_q, bus_if.reg_rd_addr_i[1:0]);
            end
          end
        end
      end
    endcase
    rd_data_d = bus_if.reg_rd_en_i ? rd_byte : rd_data_q;
    snap_d    = (bus_if.reg_rd_en_i && snap_ld) ? snap_src : snap_q;
  end

  // Gate time staging, committed value and the one-cycle update pulse
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      gate_q     <= DEFAULT_GATE_TIME;
      stage_q    <= DEFAULT_GATE_TIME;
      gate_upd_q <= 1'b0;
    end else begin
      gate_q     <= gate_d;
      stage_q    <= stage_d;
      gate_upd_q <= gate_upd_d;
    end
  end

  // Atomic result capture and the sticky ready flag
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      res_q       <= '0;
      res_ready_q <= 1'b0;
    end else begin
      if (res_valid_i) res_q <= res_data_i;
      res_ready_q <= res_ready_d;
    end
  end

  // Registered read data and shared snapshot (pre-capture values on collision)
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_data_q <= 8'h00;
      snap_q    <= 32'h0;
    end else begin
      rd_data_q <= rd_data_d;
      snap_q    <= snap_d;
    end
  end

  assign bus_if.reg_rd_data_o = rd_data_q;
  assign reg_gate_time_o      = gate_q;
  assign reg_gate_upd_o       = gate_upd_q;
  assign reg_res_ready_o      = res_ready_q;

endmodule
